hdma_scheduler: RTL
===================

# hdma_scheduler

Sequences the DMA engine for all three CGB transfer types: General-purpose DMA (GDMA), HBlank DMA (HDMA) and OAM DMA. Owns the HDMA5 control/status register behaviour and issues one block request per 16-byte unit. Arbitrates between CPU-initiated GDMA/HDMA and OAM DMA requests, and stalls the CPU while a GDMA or HDMA block is in flight. Sits between the CPU register file (FF46, FF51–FF55), the LCD controller mode outputs and the DMA engine.

## Interface
- WDT_CYCLES, 255: watchdog limit in clocks per block, used only with the watchdog macro.
- clk4_2  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hdma5_wr  in  1  one-cycle CPU write strobe to FF55.
- cpu_wr_data  in  8  data accompanying hdma5_wr.
- oam_dma_req  in  1  one-cycle CPU write strobe to FF46.
- lcd_on  in  1  LCDC bit 7.
- lcd_mode  in  2  STAT mode; 2'b00 is HBlank.
- block_done  in  1  one-cycle pulse from the engine when the current unit is complete.
- dma_start  out  1  one-cycle request to the engine.
- dma_mode  out  2  00 none, 01 GDMA, 10 HDMA, 11 OAM; held stable from dma_start until block_done.
- block_index  out  7  16-byte block offset the engine adds to the HDMA1–4 source/destination.
- HDMA5_rd  out  8  FF55 read value.
- cpu_stall  out  1  CPU halt request.
- dma_busy  out  1  any transfer armed or in flight.
- dma_error  out  1  sticky watchdog abort flag; exists only with the watchdog macro.

## Operation
- States: IDLE, GDMA_RUN, HDMA_ARMED, HDMA_RUN, HDMA_HOLD, OAM_RUN.
- `blocks_left` is 8 bits wide, range 1..128. A write loads `{1'b0, cpu_wr_data[6:0]} + 1`. `block_index` resets to 0 on every load.
- **IDLE**, hdma5_wr with bit 7 = 0:
  - -> GDMA_RUN.
  - Issue dma_start per block, back-to-back.
  - After each block_done: increment block_index, decrement blocks_left.
  - When blocks_left reaches 0 -> IDLE.
- **IDLE**, hdma5_wr with bit 7 = 1:
  - If lcd_on = 0, -> HDMA_RUN immediately (first block without HBlank).
  - Otherwise -> HDMA_ARMED.
- **HDMA_ARMED**:
  - On the rising edge of (lcd_on && lcd_mode == 2'b00) -> HDMA_RUN.
  - Being already in HBlank when armed does not count as an edge.
- **HDMA_RUN**: one block; on block_done -> HDMA_HOLD (or IDLE if blocks_left reaches 0).
- **HDMA_HOLD**: waits until lcd_mode leaves 00, then -> HDMA_ARMED.
- **HDMA termination**: hdma5_wr with bit 7 = 0 while in HDMA_ARMED or HDMA_HOLD goes to IDLE immediately. In HDMA_RUN, the current block finishes first, then -> IDLE.
  - After termination, HDMA5_rd = `{1'b1, blocks_left - 1}`.
  - hdma5_wr with bit 7 = 1 during an active HDMA reloads blocks_left and keeps the current state.
- **OAM**: oam_dma_req sets `oam_pending`. oam_pending is serviced only from IDLE, HDMA_ARMED or HDMA_HOLD, never mid-block.
  - OAM_RUN issues one dma_start with dma_mode = 11. On block_done it returns to the prior state.
- **Simultaneous hdma5_wr and oam_dma_req in IDLE**: the GDMA/HDMA write is taken; OAM stays pending. A second oam_dma_req while pending is absorbed.
- **HDMA5_rd**:
  - 8'hFF when idle after completion.
  - `{1'b0, blocks_left - 1}` while HDMA is active.
  - Terminated value as above.
- **cpu_stall**: high in GDMA_RUN and HDMA_RUN; low in OAM_RUN.
- **dma_busy**: high in every state except IDLE with oam_pending = 0.

## Timing
- Reset values: state IDLE, dma_start 0, dma_mode 00, block_index 0, HDMA5_rd 8'hFF, cpu_stall 0, dma_busy 0, dma_error 0, oam_pending 0.
- dma_start is registered: hdma5_wr at cycle N gives dma_start at N+1. cpu_stall rises at N+1.
- GDMA next block: block_done at cycle M gives the next dma_start at M+1.
- HDMA: HBlank edge sampled at cycle M gives dma_start at M+1.
- cpu_stall falls the cycle after the final block_done.
- HDMA5_rd updates the cycle after block_done.
- Reset mid-transfer returns all state to the reset values at the next edge. The engine is expected to be reset on the same signal.

## Configuration
- Macro: `HDMA_SCHED_WATCHDOG_EN`.
- Defined: a counter runs from each dma_start. If block_done is absent for WDT_CYCLES clocks, the scheduler forces IDLE, clears oam_pending, sets dma_error (cleared only by reset) and leaves HDMA5_rd = 8'hFF.
- Undefined: no counter and no dma_error port. The scheduler waits indefinitely for block_done.

## Structure
- Package `dma_pkg`:
  - state enum and dma_mode encodings;
  - BLOCK_BYTES = 16, HDMA5_IDLE = 8'hFF, MAX_BLOCKS = 128.
- Sub-module `hblank_edge`: registers lcd_on/lcd_mode and outputs hblank_rise and hblank_exit pulses.

## Test plan
- GDMA: write 8'h02 -> three dma_start pulses, block_index 0, 1, 2, cpu_stall high throughout, HDMA5_rd = 8'hFF after the last block.
- HDMA: write 8'h81 with lcd_on = 1 -> no start until HBlank entry; one block per HBlank; HDMA5_rd 8'h00 after the first block, 8'hFF after the second.
- Termination: start HDMA 8'h85, then write 8'h00 in HDMA_HOLD after 2 blocks -> IDLE, HDMA5_rd = 8'h83.
- Arbitration: oam_dma_req during an HDMA block -> OAM start issued after block_done in HDMA_HOLD; HDMA resumes on the next HBlank.
- LCD off: write 8'h80 with lcd_on = 0 -> immediate single block, then IDLE.
- Watchdog (macro on): dma_start with no block_done -> dma_error set after 255 clocks, state IDLE.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared state and transfer-mode encodings for the HDMA scheduler
package dma_pkg;
  localparam int BLOCK_BYTES = 16;
  localparam int MAX_BLOCKS = 128;
  localparam logic [7:0] HDMA5_IDLE = 8'hFF;
  typedef enum logic [2:0] {IDLE, GDMA_RUN, HDMA_ARMED, HDMA_RUN, HDMA_HOLD, OAM_RUN} state_t;
  typedef enum logic [1:0] {MODE_NONE = 2'b00, MODE_GDMA = 2'b01, MODE_HDMA = 2'b10, MODE_OAM = 2'b11} mode_t;
endpackage

// File: rtl/hblank_edge.sv
// hblank_edge: registers the HBlank level and flags its entry and exit edges
module hblank_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_on,
  input  logic [1:0] lcd_mode,
  output logic       in_hblank,
  output logic       hblank_rise,
  output logic       hblank_exit
);
  logic prev;
  assign in_hblank = lcd_on && lcd_mode == 2'b00;
  assign hblank_rise = in_hblank && !prev;
  assign hblank_exit = !in_hblank && prev;
  always_ff @(posedge clk)
    prev <= rst ? 1'b0 : in_hblank;
endmodule

// File: rtl/hdma_scheduler.sv
// hdma_scheduler: GDMA/HDMA/OAM DMA sequencing, FF55 status and CPU stall
// Optional block watchdog and dma_error port: define HDMA_SCHED_WATCHDOG_EN.
module hdma_scheduler
  import dma_pkg::*;
`ifdef HDMA_SCHED_WATCHDOG_EN
  #(parameter int WDT_CYCLES = 255)
`endif
(
  input  logic       clk4_2,
  input  logic       reset,
  input  logic       hdma5_wr,
  input  logic [7:0] cpu_wr_data,
  input  logic       oam_dma_req,
  input  logic       lcd_on,
  input  logic [1:0] lcd_mode,
  input  logic       block_done,
  output logic       dma_start,
  output logic [1:0] dma_mode,
  output logic [6:0] block_index,
  output logic [7:0] HDMA5_rd,
  output logic       cpu_stall,
  output logic       dma_busy
`ifdef HDMA_SCHED_WATCHDOG_EN
  , output logic     dma_error
`endif
);
  localparam int LEFT_W = $clog2(MAX_BLOCKS) + 1;
  state_t state, state_n, ret, base, base_n;
  logic [LEFT_W-1:0] blocks_left, left_n;
  logic [6:0] idx_n;
  logic oam_pending, pend_n, stop_req, stop_n, stopped, stopped_n, start_n;
  logic in_hblank, hblank_rise, hblank_exit, hdma_act, load, stop_now, oam_go, running, timeout;
  hblank_edge u_edge (
    .clk(clk4_2), .rst(reset), .lcd_on(lcd_on), .lcd_mode(lcd_mode),
    .in_hblank(in_hblank), .hblank_rise(hblank_rise), .hblank_exit(hblank_exit)
  );
  assign running = state == GDMA_RUN || state == HDMA_RUN || state == OAM_RUN;
  assign cpu_stall = state == GDMA_RUN || state == HDMA_RUN;
  assign dma_busy = state != IDLE || oam_pending;
  assign dma_mode = state == GDMA_RUN ? MODE_GDMA : state == HDMA_RUN ? MODE_HDMA :
                    state == OAM_RUN ? MODE_OAM : MODE_NONE;
  assign HDMA5_rd = stopped ? {1'b1, 7'(blocks_left - 1'b1)} :
                    blocks_left == '0 ? HDMA5_IDLE : {1'b0, 7'(blocks_left - 1'b1)};
  // During OAM_RUN, CPU writes act on the suspended state held in ret
  always_comb begin
    base = state == OAM_RUN ? ret : state;
    hdma_act = base == HDMA_ARMED || base == HDMA_RUN || base == HDMA_HOLD;
    load = hdma5_wr && (base == IDLE || (cpu_wr_data[7] && hdma_act));
    stop_now = stop_req || (hdma5_wr && !cpu_wr_data[7] && hdma_act);
    base_n = base;
    left_n = load ? {1'b0, cpu_wr_data[6:0]} + 1'b1 : blocks_left;
    idx_n = load ? 7'd0 : block_index;
    stop_n = !load && stop_now;
    stopped_n = !load && stopped;
    pend_n = oam_pending || oam_dma_req;
    if (hdma5_wr && base == IDLE)
      base_n = !cpu_wr_data[7] ? GDMA_RUN : lcd_on ? HDMA_ARMED : HDMA_RUN;
    if (hdma5_wr && !cpu_wr_data[7] && (base == HDMA_ARMED || base == HDMA_HOLD)) begin
      base_n = IDLE;
      stopped_n = 1'b1;
      stop_n = 1'b0;
    end
    if (block_done && cpu_stall && !load) begin
      left_n = blocks_left - 1'b1;
      idx_n = block_index + 7'd1;
    end
    if (block_done && state == GDMA_RUN)
      base_n = blocks_left == 1 ? IDLE : GDMA_RUN;
    if (block_done && state == HDMA_RUN) begin
      base_n = load ? HDMA_HOLD : (blocks_left == 1 || stop_now) ? IDLE : HDMA_HOLD;
      stopped_n = !load && blocks_left != 1 && stop_now;
      stop_n = 1'b0;
    end
    if (state == HDMA_ARMED && hblank_rise && base_n == HDMA_ARMED)
      base_n = HDMA_RUN;
    if (state == HDMA_HOLD && base_n == HDMA_HOLD && (hblank_exit || !in_hblank))
      base_n = HDMA_ARMED;
    oam_go = oam_pending && !hdma5_wr &&
             (state == IDLE || state == HDMA_HOLD || (state == HDMA_ARMED && !hblank_rise));
    if (oam_go)
      pend_n = 1'b0;
    state_n = oam_go || (state == OAM_RUN && !block_done) ? OAM_RUN : base_n;
    start_n = (state_n == GDMA_RUN || state_n == HDMA_RUN || state_n == OAM_RUN) &&
              (state_n != state || block_done);
    if (timeout) begin
      state_n = IDLE;
      pend_n = 1'b0;
      left_n = '0;
      stopped_n = 1'b0;
      stop_n = 1'b0;
      start_n = 1'b0;
    end
  end
  always_ff @(posedge clk4_2)
    if (reset) begin
      state <= IDLE;
      ret <= IDLE;
      blocks_left <= '0;
      block_index <= '0;
      oam_pending <= 1'b0;
      stop_req <= 1'b0;
      stopped <= 1'b0;
      dma_start <= 1'b0;
    end else begin
      state <= state_n;
      ret <= base_n;
      blocks_left <= left_n;
      block_index <= idx_n;
      oam_pending <= pend_n;
      stop_req <= stop_n;
      stopped <= stopped_n;
      dma_start <= start_n;
    end
`ifdef HDMA_SCHED_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt;
  assign timeout = running && !block_done && wdt == WDT_W'(WDT_CYCLES - 1);
  always_ff @(posedge clk4_2)
    if (reset) begin
      wdt <= '0;
      dma_error <= 1'b0;
    end else begin
      wdt <= start_n ? '0 : wdt + WDT_W'(1);
      dma_error <= dma_error || timeout;
    end
`else
  assign timeout = 1'b0 && running;
`endif
endmodule
